// File: rtl/i2c_codec_responder.sv
// I2C write-only target modelling the WM8731 control port. It decodes
// START, device address, {reg[6:0],data[8]} and data[7:0], ACKs valid bytes,
// and commits each complete frame into a 9-bit register file.
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'b0011010,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk,
  input  logic       i_sdat,
  output logic       o_sdat,
  output logic       o_oen,
  output logic       o_wr_valid,
  output logic [6:0] o_wr_addr,
  output logic [8:0] o_wr_data,
  input  logic [6:0] i_rd_addr,
  output logic [8:0] o_rd_data,
  output logic       o_busy,
  output logic [7:0] o_wr_count,
  output logic       o_nack_seen
);

  localparam int         LP_AW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] LP_NUM = 8'(NUM_REGS);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_REG, S_ACK_R, S_DATA, S_ACK_D, S_WAIT_STOP, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclSync, r_sdaSync;
  logic                   r_sclPrev, r_sdaPrev;
  state_t                 r_state, w_nState;
  logic [3:0]             r_bitCnt, w_nBitCnt;
  logic [7:0]             r_shift, w_nShift;
  logic [6:0]             r_regAddr, w_nRegAddr;
  logic                   r_data8, w_nData8;
  logic                   r_oen, w_nOen;
  logic                   r_busy, w_nBusy;
  logic                   r_nackSeen, w_nNack;
  logic                   w_commit;
  logic                   r_wrValid;
  logic [6:0]             r_wrAddr;
  logic [8:0]             r_wrData;
  logic [7:0]             r_wrCount;
  logic [8:0]             r_regs [NUM_REGS];
  logic [8:0]             w_rdData;

  logic w_scl, w_sda, w_sclRise, w_sclFall, w_start, w_stop;

  assign w_scl     = r_sclSync[SYNC_STAGES-1];
  assign w_sda     = r_sdaSync[SYNC_STAGES-1];
  assign w_sclRise = w_scl & ~r_sclPrev;
  assign w_sclFall = ~w_scl & r_sclPrev;
  assign w_start   = w_scl & r_sclPrev & ~w_sda & r_sdaPrev;
  assign w_stop    = w_scl & r_sclPrev & w_sda & ~r_sdaPrev;

  // Synchronise the asynchronous bus lines; reset to 1 so an idle bus shows no edges.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclSync <= '1;
      r_sdaSync <= '1;
      r_sclPrev <= 1'b1;
      r_sdaPrev <= 1'b1;
    end else begin
      r_sclSync <= {r_sclSync[SYNC_STAGES-2:0], i_sclk};
      r_sdaSync <= {r_sdaSync[SYNC_STAGES-2:0], i_sdat};
      r_sclPrev <= w_scl;
      r_sdaPrev <= w_sda;
    end
  end

  // Frame decoder: START/STOP override everything, bits shift in on SCL rise,
  // byte decisions and ACK release happen on SCL fall.
  always_comb begin
    w_nState   = r_state;
    w_nBitCnt  = r_bitCnt;
    w_nShift   = r_shift;
    w_nRegAddr = r_regAddr;
    w_nData8   = r_data8;
    w_nOen     = r_oen;
    w_nBusy    = r_busy;
    w_nNack    = r_nackSeen;
    w_commit   = 1'b0;
    if (w_stop) begin
      w_nState  = S_IDLE;
      w_nBusy   = 1'b0;
      w_nOen    = 1'b0;
      w_nBitCnt = '0;
    end else if (w_start) begin
      w_nState  = S_ADDR;
      w_nBusy   = 1'b1;
      w_nOen    = 1'b0;
      w_nBitCnt = '0;
    end else begin
      case (r_state)
        S_ADDR, S_REG, S_DATA: begin
          if (w_sclRise) begin
            w_nShift  = {r_shift[6:0], w_sda};
            w_nBitCnt = r_bitCnt + 4'd1;
          end else if (w_sclFall && r_bitCnt == 4'd8) begin
            w_nBitCnt = '0;
            if (r_state == S_ADDR) begin
              if (r_shift == {DEV_ADDR, 1'b0}) begin
                w_nState = S_ACK_A;
                w_nOen   = 1'b1;
              end else begin
                w_nState = S_IGNORE;
                w_nNack  = 1'b1;
              end
            end else if (r_state == S_REG) begin
              if ({1'b0, r_shift[7:1]} < LP_NUM) begin
                w_nState   = S_ACK_R;
                w_nOen     = 1'b1;
                w_nRegAddr = r_shift[7:1];
                w_nData8   = r_shift[0];
              end else begin
                w_nState = S_IGNORE;
                w_nNack  = 1'b1;
              end
            end else begin
              w_nState = S_ACK_D;
              w_nOen   = 1'b1;
              w_commit = 1'b1;
            end
          end
        end
        S_ACK_A, S_ACK_R, S_ACK_D: begin
          if (w_sclFall) begin
            w_nOen    = 1'b0;
            w_nBitCnt = '0;
            if (r_state == S_ACK_A)      w_nState = S_REG;
            else if (r_state == S_ACK_R) w_nState = S_DATA;
            else                         w_nState = S_WAIT_STOP;
          end
        end
        S_WAIT_STOP: begin
          if (w_sclRise) begin
            w_nBitCnt = r_bitCnt + 4'd1;
          end else if (w_sclFall) begin
            if (r_bitCnt == 4'd8) w_nNack   = 1'b1;
            if (r_bitCnt >= 4'd9) w_nBitCnt = '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Decoder state and frame-tracking registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_regAddr  <= '0;
      r_data8    <= 1'b0;
      r_oen      <= 1'b0;
      r_busy     <= 1'b0;
      r_nackSeen <= 1'b0;
    end else begin
      r_state    <= w_nState;
      r_bitCnt   <= w_nBitCnt;
      r_shift    <= w_nShift;
      r_regAddr  <= w_nRegAddr;
      r_data8    <= w_nData8;
      r_oen      <= w_nOen;
      r_busy     <= w_nBusy;
      r_nackSeen <= w_nNack;
    end
  end

  // Commit a completed frame into the register file and the write-report outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrValid <= 1'b0;
      r_wrAddr  <= '0;
      r_wrData  <= '0;
      r_wrCount <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wrValid <= w_commit;
      if (w_commit) begin
        r_regs[r_regAddr[LP_AW-1:0]] <= {r_data8, r_shift};
        r_wrAddr  <= r_regAddr;
        r_wrData  <= {r_data8, r_shift};
        r_wrCount <= r_wrCount + 8'd1;
      end
    end
  end

  // Combinational read-back; out-of-range addresses read as zero.
  always_comb begin
    w_rdData = '0;
    if ({1'b0, i_rd_addr} < LP_NUM) w_rdData = r_regs[i_rd_addr[LP_AW-1:0]];
  end

  assign o_sdat      = 1'b0;
  assign o_oen       = r_oen;
  assign o_wr_valid  = r_wrValid;
  assign o_wr_addr   = r_wrAddr;
  assign o_wr_data   = r_wrData;
  assign o_rd_data   = w_rdData;
  assign o_busy      = r_busy;
  assign o_wr_count  = r_wrCount;
  assign o_nack_seen = r_nackSeen;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Self-checking bench for i2c_codec_responder: an open-drain I2C master
// drives frames and a frame-level model predicts ACKs, writes and flags.
module tb_i2c_codec_responder;

  localparam int Q = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclDrv;
  logic       mPull;
  logic [6:0] rdAddr;
  logic       sdatOut, oen, wrValid, busy, nackSeen;
  logic [6:0] wrAddr;
  logic [8:0] wrData, rdData;
  logic [7:0] wrCount;
  logic       sdaLine;

  assign sdaLine = ~(mPull | oen);

  // 100 MHz system clock.
  always #5 clk = ~clk;

  i2c_codec_responder dut (
    .i_clk(clk), .i_rst(rst), .i_sclk(sclDrv), .i_sdat(sdaLine),
    .o_sdat(sdatOut), .o_oen(oen), .o_wr_valid(wrValid), .o_wr_addr(wrAddr),
    .o_wr_data(wrData), .i_rd_addr(rdAddr), .o_rd_data(rdData), .o_busy(busy),
    .o_wr_count(wrCount), .o_nack_seen(nackSeen)
  );

  int testsRun = 0;
  int testsFailed = 0;
  int pulseCount = 0;

  logic [8:0] mRegs [16];
  int         mCount;
  bit         mNack;
  logic [6:0] mLastAddr;
  logic [8:0] mLastData;

  // Count commit pulses as seen on the wire.
  always @(negedge clk) if (wrValid) pulseCount++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mRegs[i] = '0;
    mCount = 0;
    mNack = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic startCond();
    if (!sclDrv) begin
      #Q mPull = 1'b0;
      #Q sclDrv = 1'b1;
    end
    #Q mPull = 1'b1;
    #Q sclDrv = 1'b0;
  endtask

  task automatic stopCond();
    #Q mPull = 1'b1;
    #Q sclDrv = 1'b1;
    #Q mPull = 1'b0;
    #(4*Q);
  endtask

  task automatic sendBits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      #Q mPull = ~b[i];
      #Q sclDrv = 1'b1;
      #(2*Q) sclDrv = 1'b0;
    end
  endtask

  task automatic ackClock(output logic ack, output logic oenSeen);
    #Q mPull = 1'b0;
    #Q sclDrv = 1'b1;
    #Q ack = ~sdaLine;
    oenSeen = oen;
    #Q sclDrv = 1'b0;
  endtask

  task automatic checkRegs(input string tag);
    for (int a = 0; a < 18; a++) begin
      @(negedge clk) rdAddr = 7'(a);
      #1 checkOutput($sformatf("%s_r%0d", tag, a), 32'(rdData), (a < 16) ? 32'(mRegs[a]) : 32'd0);
    end
    @(negedge clk) rdAddr = 7'd127;
    #1 checkOutput($sformatf("%s_r127", tag), 32'(rdData), 32'd0);
    @(negedge clk);
  endtask

  // Send one frame of n bytes (MSB byte of 'frame' first) and check it against the model.
  task automatic applyStimulus(input logic [31:0] frame, input int n, input bit withStop);
    int         phase;
    int         pulsesBefore;
    bit         committed;
    bit         expAck;
    logic       ack, oenS;
    logic [7:0] b;
    logic [6:0] tReg;
    logic       tD8;
    phase = 0;
    committed = 1'b0;
    tReg = '0;
    tD8 = 1'b0;
    pulsesBefore = pulseCount;
    startCond();
    checkOutput("busyAfterStart", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      b = frame[31-8*i -: 8];
      case (phase)
        0: expAck = (b == 8'h34);
        1: expAck = (b[7:1] < 7'd16);
        2: expAck = 1'b1;
        default: expAck = 1'b0;
      endcase
      sendBits(b, 8);
      ackClock(ack, oenS);
      checkOutput($sformatf("ack%0d_%02h", i, b), 32'(ack), 32'(expAck));
      checkOutput($sformatf("oen%0d_%02h", i, b), 32'(oenS), 32'(expAck));
      case (phase)
        0: if (expAck) phase = 1; else begin mNack = 1'b1; phase = 4; end
        1: if (expAck) begin tReg = b[7:1]; tD8 = b[0]; phase = 2; end
           else begin mNack = 1'b1; phase = 4; end
        2: begin
          mRegs[tReg] = {tD8, b};
          mCount = (mCount + 1) % 256;
          mLastAddr = tReg;
          mLastData = {tD8, b};
          committed = 1'b1;
          phase = 3;
        end
        3: mNack = 1'b1;
        default: ;
      endcase
    end
    if (withStop) begin
      stopCond();
      checkOutput("busyAfterStop", 32'(busy), 32'd0);
      checkOutput("oenAfterStop", 32'(oen), 32'd0);
    end
    checkOutput("wrCount", 32'(wrCount), 32'(mCount));
    checkOutput("nackSeen", 32'(nackSeen), 32'(mNack));
    checkOutput("wrPulses", 32'(pulseCount - pulsesBefore), 32'(committed));
    if (committed) begin
      checkOutput("wrAddr", 32'(wrAddr), 32'(mLastAddr));
      checkOutput("wrData", 32'(wrData), 32'(mLastData));
    end
  endtask

  logic [8:0] initVals [10];

  initial begin
    logic       ack, oenS;
    logic [7:0] a, rb, db, eb;
    int         rsel, n;
    bit         st;
    rst = 1'b1;
    sclDrv = 1'b1;
    mPull = 1'b0;
    rdAddr = '0;
    initVals[0] = 9'h097; initVals[1] = 9'h017; initVals[2] = 9'h079;
    initVals[3] = 9'h079; initVals[4] = 9'h015; initVals[5] = 9'h000;
    initVals[6] = 9'h000; initVals[7] = 9'h042; initVals[8] = 9'h000;
    initVals[9] = 9'h001;
    doReset();
    #1;
    checkOutput("rstOen", 32'(oen), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstValid", 32'(wrValid), 32'd0);
    checkOutput("rstCount", 32'(wrCount), 32'd0);
    checkOutput("rstNack", 32'(nackSeen), 32'd0);
    checkOutput("rstWrAddr", 32'(wrAddr), 32'd0);
    checkOutput("rstWrData", 32'(wrData), 32'd0);
    checkOutput("sdatConst", 32'(sdatOut), 32'd0);
    checkRegs("rst");

    applyStimulus(32'h34_00_97_00, 3, 1'b1);
    checkRegs("single");

    doReset();
    for (int k = 9; k >= 0; k--)
      applyStimulus({8'h34, 7'(k), initVals[k][8], initVals[k][7:0], 8'h00}, 3, 1'b1);
    checkOutput("initCount", 32'(wrCount), 32'd10);
    checkOutput("initNack", 32'(nackSeen), 32'd0);
    checkRegs("init");

    applyStimulus(32'h36_00_55_00, 3, 1'b1);
    checkRegs("badAddr");
    applyStimulus(32'h35_00_55_00, 3, 1'b1);
    applyStimulus(32'h34_20_55_00, 3, 1'b1);
    checkRegs("readReg16");

    applyStimulus(32'h34_08_00_00, 2, 1'b1);
    applyStimulus(32'h34_08_15_00, 3, 1'b1);
    checkRegs("abort");

    startCond();
    sendBits(8'h34, 8);
    ackClock(ack, oenS);
    checkOutput("rsAddrAck", 32'(ack), 32'd1);
    sendBits(8'h02, 8);
    ackClock(ack, oenS);
    checkOutput("rsRegAck", 32'(ack), 32'd1);
    sendBits(8'hAB, 4);
    applyStimulus(32'h34_06_00_00, 2, 1'b1);
    checkRegs("restart");
    applyStimulus(32'h34_0A_33_C3, 4, 1'b1);

    startCond();
    sendBits(8'h34, 8);
    #Q mPull = 1'b0;
    for (int c = 0; c < 20 && !oen; c++) @(negedge clk);
    @(negedge clk);
    checkOutput("oenBeforeReset", 32'(oen), 32'd1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    modelReset();
    checkOutput("rstMidOen", 32'(oen), 32'd0);
    checkOutput("rstMidBusy", 32'(busy), 32'd0);
    checkOutput("rstMidCount", 32'(wrCount), 32'd0);
    checkOutput("rstMidNack", 32'(nackSeen), 32'd0);
    #Q sclDrv = 1'b1;
    #(2*Q) sclDrv = 1'b0;
    stopCond();
    checkRegs("midReset");
    applyStimulus(32'h34_0E_5C_00, 3, 1'b1);

    for (int t = 0; t < 25; t++) begin
      rsel = $urandom_range(0, 9);
      a = (rsel == 0) ? 8'h35 : (rsel == 1) ? 8'h36 : 8'h34;
      rb = {7'($urandom_range(0, 19)), 1'($urandom)};
      db = 8'($urandom);
      eb = 8'($urandom);
      n = $urandom_range(1, 4);
      st = ($urandom_range(0, 4) != 0);
      applyStimulus({a, rb, db, eb}, n, st);
    end
    if (!sclDrv) stopCond();
    checkRegs("random");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
